// File: rtl/intmul_arb_pkg.sv
// Shared types and sizing helpers for the shared-multiplier arbiter.
// The INTMUL_ARBITER_STATS_EN build adds the counters sized by STATW.
package intmul_arb_pkg;

  localparam int unsigned STATW = 32;
  // Wide enough for the largest supported requester count (16)
  localparam int unsigned IDW   = 4;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  function automatic int unsigned tagw(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int unsigned cw(input int unsigned loga, input int unsigned logb);
    return loga + logb;
  endfunction

endpackage

// File: rtl/intmul_arb_rr.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo NREQ.
module intmul_arb_rr
  import intmul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = tagw(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      j = (32'(ptr) + off) % NREQ;
      if (!any && elig[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/intmul_arbiter.sv
// Round-robin sharing of one pipelined LOGA x LOGB multiplier among NREQ
// requesters. Optional counters enabled by INTMUL_ARBITER_STATS_EN.
module intmul_arbiter
  import intmul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LOGA = 60,
  parameter int unsigned LOGB = 60,
  parameter int unsigned LAT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*LOGA-1:0]         req_A,
  input  logic [NREQ*LOGB-1:0]         req_B,
  output logic [NREQ-1:0]              res_valid,
  input  logic [NREQ-1:0]              res_ready,
  output logic [NREQ*(LOGA+LOGB)-1:0]  res_C,
  output logic [LOGA-1:0]              mul_A,
  output logic [LOGB-1:0]              mul_B,
  input  logic [LOGA+LOGB-1:0]         mul_C
`ifdef INTMUL_ARBITER_STATS_EN
  ,
  output logic [STATW-1:0]             stat_ops,
  output logic [STATW-1:0]             stat_idle
`endif
);

  localparam int unsigned TAGW = tagw(NREQ);
  localparam int unsigned CW   = cw(LOGA, LOGB);

  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [TAGW-1:0] ptr;
  logic [TAGW-1:0] gidx;
  logic            gany;
  logic [LOGA-1:0] sel_A;
  logic [LOGB-1:0] sel_B;

  // tags[0] sits alongside mul_A/mul_B; tags[LAT] lines up with mul_C
  tag_t tags [LAT+1];
  tag_t tail;

  assign elig      = req_valid & ~busy & {NREQ{rst}};
  assign req_ready = grant;
  assign sel_A     = req_A[gidx*LOGA +: LOGA];
  assign sel_B     = req_B[gidx*LOGB +: LOGB];
  assign tail      = tags[LAT];

  intmul_arb_rr #(
    .NREQ (NREQ),
    .PW   (TAGW)
  ) u_rr (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= '0;
      res_valid <= '0;
      res_C     <= '0;
      mul_A     <= '0;
      mul_B     <= '0;
      ptr       <= '0;
      for (int unsigned s = 0; s <= LAT; s++) tags[s] <= '0;
    end else begin
      mul_A   <= gany ? sel_A : '0;
      mul_B   <= gany ? sel_B : '0;
      tags[0] <= '{valid: gany, id: IDW'(gidx)};
      for (int unsigned s = 1; s <= LAT; s++) tags[s] <= tags[s-1];
      if (gany) ptr <= (32'(gidx) == NREQ - 1) ? '0 : gidx + TAGW'(1);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i])
          busy[i] <= 1'b1;
        else if (res_valid[i] && res_ready[i])
          busy[i] <= 1'b0;
        if (tail.valid && (32'(tail.id) == i)) begin
          res_valid[i]        <= 1'b1;
          res_C[i*CW +: CW]   <= mul_C;
        end else if (res_valid[i] && res_ready[i]) begin
          res_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef INTMUL_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_ops  <= '0;
      stat_idle <= '0;
    end else begin
      if (gany) stat_ops <= stat_ops + STATW'(1);
      if (|req_valid && !gany) stat_idle <= stat_idle + STATW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_intmul_arbiter.sv
// Directed bench for intmul_arbiter with a behavioural LAT-stage multiplier.
// Stats checks are compiled in when INTMUL_ARBITER_STATS_EN is defined.
module tb_intmul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LOGA = 60;
  localparam int unsigned LOGB = 60;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = LOGA + LOGB;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*LOGA-1:0] req_A;
  logic [NREQ*LOGB-1:0] req_B;
  logic [NREQ-1:0]     res_valid;
  logic [NREQ-1:0]     res_ready;
  logic [NREQ*CW-1:0]  res_C;
  logic [LOGA-1:0]     mul_A;
  logic [LOGB-1:0]     mul_B;
  logic [CW-1:0]       mul_C;
`ifdef INTMUL_ARBITER_STATS_EN
  logic [31:0]         stat_ops;
  logic [31:0]         stat_idle;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  intmul_arbiter #(
    .NREQ (NREQ),
    .LOGA (LOGA),
    .LOGB (LOGB),
    .LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_C     (res_C),
    .mul_A     (mul_A),
    .mul_B     (mul_B),
    .mul_C     (mul_C)
`ifdef INTMUL_ARBITER_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_idle (stat_idle)
`endif
  );

  // Product of operands seen in cycle c appears on mul_C in cycle c+LAT
  logic [CW-1:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= CW'(mul_A) * CW'(mul_B);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_C = mp[LAT-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rc(input int unsigned j);
    return res_C[j*CW +: CW];
  endfunction

  initial begin
    rst       = 1'b0;
    req_valid = 4'b0001;
    res_ready = '0;
    req_A     = '0;
    req_B     = '0;
    req_A[LOGA-1:0] = '1;
    req_B[LOGB-1:0] = '1;
    #1;
    chk("ready_in_reset", 128'(req_ready), 128'h0);
    step();
    step();
    chk("reset_ready", 128'(req_ready), 128'h0);
    chk("reset_res_valid", 128'(res_valid), 128'h0);
    chk("reset_mul_A", 128'(mul_A), 128'h0);
    chk("reset_mul_B", 128'(mul_B), 128'h0);
    for (int j = 0; j < 4; j++) chk("reset_res_C", 128'(rc(j)), 128'h0);

    // Single op with maximal operands
    rst = 1'b1;
    #1;
    chk("single_grant", 128'(req_ready), 128'h1);
    step();
    chk("single_mul_A", 128'(mul_A), 128'hFFF_FFFF_FFFF_FFFF);
    chk("single_busy_no_regrant", 128'(req_ready), 128'h0);
    for (int n = 0; n < 4; n++) step();
    chk("single_not_yet", 128'(res_valid), 128'h0);
    step();
    chk("single_res_valid", 128'(res_valid), 128'h1);
    chk("single_res_C", 128'(rc(0)), 128'hFF_FFFF_FFFF_FFFF_E000_0000_0000_0001);
    req_valid = '0;
    res_ready = 4'b0001;
    step();
    chk("single_consumed", 128'(res_valid), 128'h0);
    chk("single_res_C_held", 128'(rc(0)), 128'hFF_FFFF_FFFF_FFFF_E000_0000_0000_0001);
    res_ready = '0;

    // Four requesters continuously valid, pointer restarted at 0
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_A[i*LOGA +: LOGA] = LOGA'(i + 1);
      req_B[i*LOGB +: LOGB] = LOGB'(1000);
    end
    req_valid = 4'b1111;
    #1;
    chk("grant0", 128'(req_ready), 128'h1);
    step();
    chk("op0_mul_A", 128'(mul_A), 128'd1);
    chk("op0_mul_B", 128'(mul_B), 128'd1000);
    chk("grant1", 128'(req_ready), 128'h2);
    step();
    chk("op1_mul_A", 128'(mul_A), 128'd2);
    chk("grant2", 128'(req_ready), 128'h4);
    step();
    chk("grant3", 128'(req_ready), 128'h8);
    step();
    chk("op3_mul_A", 128'(mul_A), 128'd4);
    chk("all_busy", 128'(req_ready), 128'h0);
    step();
    chk("no_result_e4", 128'(res_valid), 128'h0);
    step();
    chk("res_e5", 128'(res_valid), 128'h1);
    chk("res_C0", 128'(rc(0)), 128'd1000);
    step();
    chk("res_e6", 128'(res_valid), 128'h3);
    chk("res_C1", 128'(rc(1)), 128'd2000);
    step();
    chk("res_e7", 128'(res_valid), 128'h7);
    chk("res_C2", 128'(rc(2)), 128'd3000);
    step();
    chk("res_e8", 128'(res_valid), 128'hF);
    chk("res_C3", 128'(rc(3)), 128'd4000);
    chk("no_fifth_grant", 128'(req_ready), 128'h0);

    // Backpressure on requester 2 while the others keep going
    res_ready = 4'b1011;
    step();
    chk("bp_after_consume", 128'(res_valid), 128'h4);
    res_ready = '0;
    #1;
    chk("bp_grant0", 128'(req_ready), 128'h1);
    step();
    chk("bp_grant1", 128'(req_ready), 128'h2);
    step();
    chk("bp_grant3", 128'(req_ready), 128'h8);
    step();
    chk("bp_all_busy", 128'(req_ready), 128'h0);
    for (int n = 0; n < 7; n++) begin
      step();
      chk("bp_res_valid2", 128'(res_valid[2]), 128'h1);
      chk("bp_res_C2", 128'(rc(2)), 128'd3000);
      chk("bp_no_grant2", 128'(req_ready[2]), 128'h0);
    end
    chk("bp_others_done", 128'(res_valid), 128'hF);
    chk("bp_res_C0", 128'(rc(0)), 128'd1000);
    chk("bp_res_C1", 128'(rc(1)), 128'd2000);
    req_valid = '0;
    res_ready = 4'b1111;
    step();
    chk("bp_release", 128'(res_valid), 128'h0);
    res_ready = '0;

    // Fairness: move pointer to 3, then req1 and req3 compete
    req_valid = 4'b0100;
    #1;
    chk("fair_setup_grant2", 128'(req_ready), 128'h4);
    step();
    req_valid = 4'b1010;
    #1;
    chk("fair_first3", 128'(req_ready), 128'h8);
    step();
    chk("fair_then1", 128'(req_ready), 128'h2);
    step();
    req_valid = '0;
    res_ready = 4'b1111;
    for (int n = 0; n < 8; n++) step();
    chk("fair_drained", 128'(res_valid), 128'h0);
    chk("fair_res_C3", 128'(rc(3)), 128'd4000);
    res_ready = '0;
    req_valid = 4'b1111;
    #1;
    chk("fair_ptr2", 128'(req_ready), 128'h4);

    // Reset with three ops in flight
    step();
    step();
    step();
    req_valid = '0;
    rst = 1'b0;
    step();
    chk("midrst_mul_A", 128'(mul_A), 128'h0);
    chk("midrst_mul_B", 128'(mul_B), 128'h0);
    chk("midrst_res_valid", 128'(res_valid), 128'h0);
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("midrst_no_result", 128'(res_valid), 128'h0);
    end
    req_valid = 4'b1111;
    #1;
    chk("midrst_ptr0_free", 128'(req_ready), 128'h1);
    req_valid = '0;

`ifdef INTMUL_ARBITER_STATS_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    req_valid = 4'b1111;
    for (int n = 0; n < 4; n++) step();
    for (int n = 0; n < 5; n++) step();
    req_valid = '0;
    res_ready = 4'b1111;
    for (int n = 0; n < 6; n++) step();
    res_ready = '0;
    req_valid = 4'b1111;
    for (int n = 0; n < 4; n++) step();
    req_valid = '0;
    #1;
    chk("stat_ops", 128'(stat_ops), 128'd8);
    chk("stat_idle", 128'(stat_idle), 128'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
